// File: rtl/keypad_matrix_decoder_pkg.sv
// Shared types, key codes and fill patterns for the keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_DECODE,
        ST_EMIT_OK,
        ST_EMIT_B,
        ST_EMIT_E,
        ST_RELEASE,
        ST_DISABLED
    } state_t;

    localparam logic [3:0] KEY_ENTER    = 4'hA;
    localparam logic [3:0] KEY_CANCEL   = 4'hB;
    localparam logic [3:0] KEY_BKSP     = 4'hC;
    localparam logic [3:0] KEY_NONE     = 4'hF;

    localparam logic [3:0] FILL_CANCEL  = 4'hB;
    localparam logic [3:0] FILL_TIMEOUT = 4'hE;
    localparam logic [3:0] FILL_EMPTY   = 4'hF;

    localparam logic [3:0] COLS_IDLE    = 4'b1111;

    function automatic logic [3:0] row_drive(input logic [1:0] row);
        return ~(4'b1000 >> row);
    endfunction

    // Row 3 holds '*', '0', '#', 'D'; only '0' produces a key
    function automatic logic [3:0] decode_key(input logic [1:0] row,
                                              input logic [3:0] col);
        logic [1:0] c;
        case (col)
            4'b0111: c = 2'd0;
            4'b1011: c = 2'd1;
            4'b1101: c = 2'd2;
            default: c = 2'd3;
        endcase
        if (row == 2'd3)
            return (c == 2'd1) ? 4'h0 : KEY_NONE;
        if (c == 2'd3)
            return KEY_ENTER + {2'b00, row};
        return {2'b00, row} * 4'd3 + {2'b00, c} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_matrix_decoder_debouncer.sv
// Counts consecutive cycles a column code matches a reference code.
module keypad_debouncer #(
    parameter int DEBOUNCE_CYC = 100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_sample,
    input  logic [3:0] i_ref,
    input  logic       i_start,
    output logic       o_stable,
    output logic       o_changed
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] r_cnt;
    logic          w_match;

    assign w_match = (i_sample == i_ref);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_start || !w_match)
            r_cnt <= '0;
        else if (r_cnt != LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_stable  = w_match && (r_cnt == LAST);
    assign o_changed = !w_match;

endmodule

// File: rtl/keypad_matrix_decoder.sv
// 4x4 keypad scanner: row scan, debounce, decode and digit buffering.
module keypad_matrix_decoder
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS   = 20,
    parameter int DEBOUNCE_CYC = 100,
    parameter int SETTLE_CYC   = 2,
    parameter int TIMEOUT_CYC  = 5000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [3:0]                      col_matriz,
    output logic [3:0]                      lin_matriz,
    output logic [4*MAX_DIGITS-1:0]         digitos_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digitos_count,
    output logic                            digitos_valid
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int NW = $clog2(MAX_DIGITS + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BW-1:0] ALL_F = {MAX_DIGITS{FILL_EMPTY}};
    localparam logic [BW-1:0] ALL_B = {MAX_DIGITS{FILL_CANCEL}};
    localparam logic [BW-1:0] ALL_E = {MAX_DIGITS{FILL_TIMEOUT}};
    localparam logic [BW-1:0] TOP_F = ALL_F << (BW - 4);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [NW-1:0] CNT_MAX     = NW'(MAX_DIGITS);

    state_t        r_state;
    logic [1:0]    r_row;
    logic [3:0]    r_col;
    logic [3:0]    r_lin;
    logic [SW-1:0] r_settle;
    logic [TW-1:0] r_tmo;
    logic [BW-1:0] r_buf;
    logic [NW-1:0] r_cnt;
    logic          r_valid;

    logic [3:0]    w_ref;
    logic [3:0]    w_key;
    logic [1:0]    w_next_row;
    logic          w_db_start;
    logic          w_stable;
    logic          w_changed;
    logic          w_sample;
    logic          w_key_hit;
    logic          w_tmo_run;
    logic          w_tmo_fire;

    assign w_ref      = (r_state == ST_RELEASE) ? COLS_IDLE : r_col;
    assign w_db_start = !(r_state == ST_DEBOUNCE || r_state == ST_RELEASE);
    assign w_sample   = (r_state == ST_SCAN) && (r_settle == SETTLE_LAST);
    assign w_key_hit  = w_sample && ($countones(~col_matriz) == 1);
    assign w_tmo_run  = (r_cnt != '0) &&
                        (r_state == ST_SCAN || r_state == ST_RELEASE);
    assign w_tmo_fire = w_tmo_run && (r_tmo == TMO_LAST);
    assign w_key      = decode_key(r_row, r_col);
    assign w_next_row = r_row + 2'd1;

    keypad_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sample  (col_matriz),
        .i_ref     (w_ref),
        .i_start   (w_db_start),
        .o_stable  (w_stable),
        .o_changed (w_changed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_SCAN;
            r_row    <= 2'd0;
            r_col    <= COLS_IDLE;
            r_lin    <= 4'b0111;
            r_settle <= '0;
            r_tmo    <= '0;
            r_buf    <= ALL_F;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_tmo_run)
                r_tmo <= r_tmo + 1'b1;
            case (r_state)
                ST_SCAN: begin
                    // A key latched in the expiry cycle wins over the timeout
                    if (!enable) begin
                        r_state <= ST_DISABLED;
                        r_lin   <= COLS_IDLE;
                    end else if (w_key_hit) begin
                        r_col   <= col_matriz;
                        r_tmo   <= '0;
                        r_state <= ST_DEBOUNCE;
                    end else if (w_tmo_fire) begin
                        r_buf   <= ALL_E;
                        r_valid <= 1'b1;
                        r_state <= ST_EMIT_E;
                    end else if (w_sample) begin
                        r_row    <= w_next_row;
                        r_lin    <= row_drive(w_next_row);
                        r_settle <= '0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_changed) begin
                        r_settle <= '0;
                        r_state  <= ST_SCAN;
                    end else if (w_stable) begin
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_tmo <= '0;
                    unique case (1'b1)
                        (w_key <= 4'd9): begin
                            if (r_cnt != CNT_MAX) begin
                                r_buf <= (r_buf << 4) | BW'(w_key);
                                r_cnt <= r_cnt + 1'b1;
                            end
                            r_state <= ST_RELEASE;
                        end
                        (w_key == KEY_BKSP): begin
                            if (r_cnt != '0) begin
                                r_buf <= (r_buf >> 4) | TOP_F;
                                r_cnt <= r_cnt - 1'b1;
                            end
                            r_state <= ST_RELEASE;
                        end
                        (w_key == KEY_ENTER): begin
                            r_valid <= 1'b1;
                            r_state <= ST_EMIT_OK;
                        end
                        (w_key == KEY_CANCEL): begin
                            r_buf   <= ALL_B;
                            r_valid <= 1'b1;
                            r_state <= ST_EMIT_B;
                        end
                        default: r_state <= ST_RELEASE;
                    endcase
                end
                ST_EMIT_OK, ST_EMIT_B: begin
                    r_buf   <= ALL_F;
                    r_cnt   <= '0;
                    r_tmo   <= '0;
                    r_state <= ST_RELEASE;
                end
                ST_EMIT_E: begin
                    r_buf    <= ALL_F;
                    r_cnt    <= '0;
                    r_tmo    <= '0;
                    r_settle <= '0;
                    r_state  <= ST_SCAN;
                end
                ST_RELEASE: begin
                    if (!enable) begin
                        r_state <= ST_DISABLED;
                        r_lin   <= COLS_IDLE;
                    end else if (w_tmo_fire) begin
                        r_buf   <= ALL_E;
                        r_valid <= 1'b1;
                        r_state <= ST_EMIT_E;
                    end else if (w_stable) begin
                        r_settle <= '0;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_DISABLED: begin
                    if (enable) begin
                        r_row    <= 2'd0;
                        r_lin    <= row_drive(2'd0);
                        r_settle <= '0;
                        r_state  <= ST_SCAN;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign lin_matriz    = r_lin;
    assign digitos_value = r_buf;
    assign digitos_count = r_cnt;
    assign digitos_valid = r_valid;

endmodule

// File: tb/tb_keypad_matrix_decoder.sv
// Keypad decoder bench: physical keypad model plus digit-queue reference.
module tb_keypad_matrix_decoder;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  col_matriz;
    logic [3:0]  lin_matriz;
    logic [15:0] digitos_value;
    logic [2:0]  digitos_count;
    logic        digitos_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic       pressed = 1'b0;
    logic       glitch  = 1'b0;
    logic [1:0] prow = 2'd0;
    logic [1:0] pcol = 2'd0;
    logic [3:0] gval = 4'hF;

    // Key ids: 0-9 digits, 10 ENTER, 11 CANCEL, 12 BKSP, 13 '*', 14 '#', 15 'D'
    int kmap [4][4] = '{'{1, 2, 3, 10},
                        '{4, 5, 6, 11},
                        '{7, 8, 9, 12},
                        '{13, 0, 14, 15}};

    int          q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    keypad_matrix_decoder #(
        .MAX_DIGITS   (MAXD),
        .DEBOUNCE_CYC (4),
        .SETTLE_CYC   (2),
        .TIMEOUT_CYC  (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .col_matriz    (col_matriz),
        .lin_matriz    (lin_matriz),
        .digitos_value (digitos_value),
        .digitos_count (digitos_count),
        .digitos_valid (digitos_valid)
    );

    always #5 clk = ~clk;

    // A pressed switch shorts its column low only while its row is driven low
    always_comb begin
        col_matriz = 4'hF;
        if (glitch)
            col_matriz = gval;
        else if (pressed && !lin_matriz[2'd3 - prow])
            col_matriz[2'd3 - pcol] = 1'b0;
    end

    always @(negedge clk)
        if (digitos_valid === 1'b1)
            obs_q.push_back(digitos_value);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_buf();
        logic [15:0] v;
        v = 16'hFFFF;
        for (int i = 0; i < q.size(); i++)
            v[4*i +: 4] = 4'(q[q.size() - 1 - i]);
        return v;
    endfunction

    task automatic press(input int k, input int hold, input int gap);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kmap[r][c] == k) begin
                    prow = 2'(r);
                    pcol = 2'(c);
                end
        pressed = 1'b1;
        tick(hold);
        pressed = 1'b0;
        tick(gap);
        if (k <= 9) begin
            if (q.size() < MAXD)
                q.push_back(k);
        end else if (k == 12) begin
            if (q.size() > 0)
                void'(q.pop_back());
        end else if (k == 10) begin
            exp_q.push_back(model_buf());
            q.delete();
        end else if (k == 11) begin
            exp_q.push_back(16'hBBBB);
            q.delete();
        end
    endtask

    task automatic step_check(input string tag);
        int n;
        chk({tag, ":npulse"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, ":pulse"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        chk({tag, ":count"}, digitos_count, q.size());
        chk({tag, ":value"}, digitos_value, model_buf());
    endtask

    task automatic wait_lin(input string tag, input logic [3:0] want);
        int n;
        n = 0;
        while (lin_matriz !== want && n < 40) begin
            tick(1);
            n++;
        end
        chk(tag, lin_matriz, want);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        rst    = 1'b1;
        enable = 1'b1;
        tick(3);
        chk("rst_lin", lin_matriz, 4'b0111);
        chk("rst_value", digitos_value, 16'hFFFF);
        chk("rst_count", digitos_count, 0);
        chk("rst_valid", digitos_valid, 0);
        rst = 1'b0;
        tick(5);

        press(1, 16, 12);
        press(2, 16, 12);
        press(3, 16, 12);
        step_check("t1_digits");
        press(10, 16, 12);
        step_check("t1_enter");

        wait_lin("t2_row0", 4'b0111);
        gval   = 4'b0111;
        glitch = 1'b1;
        tick(2);
        glitch = 1'b0;
        tick(20);
        step_check("t2_glitch");
        wait_lin("t2_scan", 4'b1011);

        for (int k = 1; k <= 5; k++)
            press(k, 16, 12);
        press(12, 16, 12);
        step_check("t3_bksp");
        press(10, 16, 12);
        step_check("t3_enter");

        press(5, 16, 12);
        press(11, 40, 12);
        step_check("t5_cancel");

        press(7, 16, 12);
        step_check("t4_press");
        tick(80);
        exp_q.push_back(16'hEEEE);
        q.delete();
        step_check("t4_timeout");
        tick(200);
        step_check("t4_idle");

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 10)       r = r;
            else if (r < 12)  r = 12;
            else if (r == 12) r = 10;
            else if (r == 13) r = 11;
            else if (r == 14) r = 13 + int'($urandom_range(0, 2));
            else              r = int'($urandom_range(0, 9));
            press(r, int'($urandom_range(16, 22)), int'($urandom_range(8, 14)));
            step_check("rnd");
        end
        press(10, 16, 12);
        step_check("rnd_end");

        press(1, 16, 12);
        press(2, 16, 12);
        enable = 1'b0;
        tick(3);
        chk("t6_dis_lin", lin_matriz, 4'hF);
        tick(100);
        step_check("t6_disabled");
        enable = 1'b1;
        tick(2);
        press(10, 16, 12);
        step_check("t6_enter");

        press(4, 16, 12);
        prow    = 2'd1;
        pcol    = 2'd1;
        pressed = 1'b1;
        wait_lin("t6_row1", 4'b1011);
        tick(2);
        rst = 1'b1;
        #2;
        chk("t6_rst_lin", lin_matriz, 4'b0111);
        chk("t6_rst_value", digitos_value, 16'hFFFF);
        chk("t6_rst_count", digitos_count, 0);
        chk("t6_rst_valid", digitos_valid, 0);
        pressed = 1'b0;
        q.delete();
        tick(2);
        rst = 1'b0;
        tick(30);
        step_check("t6_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
